// File: rtl/hazard_control_unit_pkg.sv
// Shared pipeline definitions: hazard FSM encoding, instruction field positions
// and the default multi-cycle EX latency.
package hazard_control_unit_pkg;

    typedef enum logic {
        RUN       = 1'b0,
        MULT_WAIT = 1'b1
    } hcu_state_e;

    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;

    localparam int unsigned DEFAULT_MULT_CYCLES = 4;

    // Wide enough for a wait-counter load of up to 16-2.
    localparam int CNT_W       = 4;
    localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: load-use stall, branch flush, and a multi-cycle EX
// wait FSM with a flush that is deferred until the wait ends.
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = DEFAULT_MULT_CYCLES
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic [31:0]            ID_instruction,
    input  logic                   EX_MemRead,
    input  logic [4:0]             EX_rt,
    input  logic                   branch_taken,
    input  logic                   mult_start,
    output logic                   PC_write,
    output logic                   IF_ID_stall,
    output logic                   IF_ID_flush,
    output logic                   ID_EX_bubble,
    output logic                   ID_EX_stall,
    output logic                   busy,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    localparam logic [CNT_W-1:0]       CNT_LOAD  = CNT_W'(MULT_CYCLES - 2);
    localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;

    hcu_state_e             r_state;
    hcu_state_e             w_next_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_next_cnt;
    logic                   r_pending_flush;
    logic                   w_next_pending_flush;
    logic [STALL_CNT_W-1:0] r_stall_cycles;

    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic       w_load_use;
    logic       w_flush;
    logic       w_unused_bits;

    assign w_rs          = ID_instruction[RS_MSB:RS_LSB];
    assign w_rt          = ID_instruction[RT_MSB:RT_LSB];
    assign w_unused_bits = ^{ID_instruction[31:26], ID_instruction[15:0]};

    // $zero is never a real producer, so a load into it cannot create a hazard.
    assign w_load_use = EX_MemRead && (EX_rt != 5'd0) && ((EX_rt == w_rs) || (EX_rt == w_rt));
    assign w_flush    = branch_taken || r_pending_flush;

    always_comb begin
        // NOTE: every output and next-state value gets a default up front so no
        // path through the case can leave one unassigned and infer a latch.
        PC_write             = 1'b1;
        IF_ID_stall          = 1'b0;
        IF_ID_flush          = 1'b0;
        ID_EX_bubble         = 1'b0;
        ID_EX_stall          = 1'b0;
        busy                 = 1'b0;
        w_next_state         = r_state;
        w_next_cnt           = r_cnt;
        w_next_pending_flush = r_pending_flush;

        if (!Rst) begin
            unique case (r_state)
                RUN: begin
                    if (w_flush) begin
                        IF_ID_flush = 1'b1;
                    end else if (w_load_use) begin
                        PC_write     = 1'b0;
                        IF_ID_stall  = 1'b1;
                        ID_EX_bubble = 1'b1;
                    end
                    w_next_pending_flush = 1'b0;
                    if (mult_start) begin
                        w_next_state = MULT_WAIT;
                        w_next_cnt   = CNT_LOAD;
                    end
                end
                MULT_WAIT: begin
                    PC_write    = 1'b0;
                    IF_ID_stall = 1'b1;
                    ID_EX_stall = 1'b1;
                    busy        = 1'b1;
                    // A branch resolved while frozen is remembered and applied on exit.
                    if (branch_taken) begin
                        w_next_pending_flush = 1'b1;
                    end
                    if (r_cnt == '0) begin
                        w_next_state = RUN;
                    end else begin
                        w_next_cnt = r_cnt - CNT_W'(1);
                    end
                end
                default: w_next_state = RUN;
            endcase
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state         <= RUN;
            r_cnt           <= '0;
            r_pending_flush <= 1'b0;
            r_stall_cycles  <= '0;
        end else begin
            r_state         <= w_next_state;
            r_cnt           <= w_next_cnt;
            r_pending_flush <= w_next_pending_flush;
            if (IF_ID_stall && (r_stall_cycles != STALL_MAX)) begin
                r_stall_cycles <= r_stall_cycles + STALL_CNT_W'(1);
            end
        end
    end

    assign stall_cycles = Rst ? '0 : r_stall_cycles;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed scenario bench for hazard_control_unit with MULT_CYCLES = 4.
module tb_hazard_control_unit;

    // Control vector order: {PC_write, IF_ID_stall, IF_ID_flush, ID_EX_bubble, ID_EX_stall, busy}
    localparam logic [5:0] CTL_RUN   = 6'b100000;
    localparam logic [5:0] CTL_LU    = 6'b010100;
    localparam logic [5:0] CTL_FLUSH = 6'b101000;
    localparam logic [5:0] CTL_WAIT  = 6'b010011;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [31:0] ID_instruction;
    logic        EX_MemRead;
    logic [4:0]  EX_rt;
    logic        branch_taken;
    logic        mult_start;
    logic        PC_write;
    logic        IF_ID_stall;
    logic        IF_ID_flush;
    logic        ID_EX_bubble;
    logic        ID_EX_stall;
    logic        busy;
    logic [15:0] stall_cycles;
    logic [5:0]  ctl;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_control_unit #(.MULT_CYCLES(4)) dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .ID_instruction (ID_instruction),
        .EX_MemRead     (EX_MemRead),
        .EX_rt          (EX_rt),
        .branch_taken   (branch_taken),
        .mult_start     (mult_start),
        .PC_write       (PC_write),
        .IF_ID_stall    (IF_ID_stall),
        .IF_ID_flush    (IF_ID_flush),
        .ID_EX_bubble   (ID_EX_bubble),
        .ID_EX_stall    (ID_EX_stall),
        .busy           (busy),
        .stall_cycles   (stall_cycles)
    );

    always #5 Clk = ~Clk;

    assign ctl = {PC_write, IF_ID_stall, IF_ID_flush, ID_EX_bubble, ID_EX_stall, busy};

    function automatic logic [31:0] mk_instr(input logic [4:0] rs, input logic [4:0] rt);
        return {6'b100011, rs, rt, 16'h0010};
    endfunction

    // Start a new cycle: just past the rising edge, inputs are redriven afterwards.
    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        EX_MemRead     = 1'b0;
        EX_rt          = 5'd0;
        branch_taken   = 1'b0;
        mult_start     = 1'b0;
        ID_instruction = mk_instr(5'd1, 5'd2);
    endtask

    task automatic do_reset();
        cyc();
        idle();
        Rst = 1'b1;
        cyc();
        Rst = 1'b0;
    endtask

    task automatic test_reset();
        cyc();
        Rst            = 1'b1;
        mult_start     = 1'b1;
        branch_taken   = 1'b1;
        EX_MemRead     = 1'b1;
        EX_rt          = 5'd5;
        ID_instruction = mk_instr(5'd5, 5'd9);
        #1;
        n_checks++;
        if (ctl !== CTL_RUN) begin n_fail++; $display("FAIL reset_ctl: got %b expected %b", ctl, CTL_RUN); end
        n_checks++;
        if (stall_cycles !== 16'd0) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cycles); end
        cyc();
        idle();
        Rst = 1'b0;
        #1;
        n_checks++;
        if (ctl !== CTL_RUN) begin n_fail++; $display("FAIL reset_release_ctl: got %b expected %b", ctl, CTL_RUN); end
        n_checks++;
        if (stall_cycles !== 16'd0) begin n_fail++; $display("FAIL reset_release_cnt: got %0d expected 0", stall_cycles); end
    endtask

    task automatic test_load_use();
        do_reset();
        cyc();
        EX_MemRead = 1'b1; EX_rt = 5'd5; ID_instruction = mk_instr(5'd5, 5'd7);
        #1;
        n_checks++;
        if (ctl !== CTL_LU) begin n_fail++; $display("FAIL lu_rs_ctl: got %b expected %b", ctl, CTL_LU); end
        cyc();
        idle();
        #1;
        n_checks++;
        if (ctl !== CTL_RUN) begin n_fail++; $display("FAIL lu_one_cycle: got %b expected %b", ctl, CTL_RUN); end
        n_checks++;
        if (stall_cycles !== 16'd1) begin n_fail++; $display("FAIL lu_stall_cnt: got %0d expected 1", stall_cycles); end
        cyc();
        EX_MemRead = 1'b1; EX_rt = 5'd7; ID_instruction = mk_instr(5'd3, 5'd7);
        #1;
        n_checks++;
        if (ctl !== CTL_LU) begin n_fail++; $display("FAIL lu_rt_ctl: got %b expected %b", ctl, CTL_LU); end
        cyc();
        idle();
        #1;
        n_checks++;
        if (stall_cycles !== 16'd2) begin n_fail++; $display("FAIL lu_rt_cnt: got %0d expected 2", stall_cycles); end
    endtask

    task automatic test_no_hazard();
        cyc();
        EX_MemRead = 1'b1; EX_rt = 5'd0; ID_instruction = mk_instr(5'd0, 5'd0);
        #1;
        n_checks++;
        if (ctl !== CTL_RUN) begin n_fail++; $display("FAIL nh_zero_reg: got %b expected %b", ctl, CTL_RUN); end
        cyc();
        EX_MemRead = 1'b1; EX_rt = 5'd5; ID_instruction = mk_instr(5'd6, 5'd6);
        #1;
        n_checks++;
        if (ctl !== CTL_RUN) begin n_fail++; $display("FAIL nh_no_match: got %b expected %b", ctl, CTL_RUN); end
        cyc();
        EX_MemRead = 1'b0; EX_rt = 5'd5; ID_instruction = mk_instr(5'd5, 5'd5);
        #1;
        n_checks++;
        if (ctl !== CTL_RUN) begin n_fail++; $display("FAIL nh_not_load: got %b expected %b", ctl, CTL_RUN); end
        cyc();
        idle();
        #1;
        n_checks++;
        if (stall_cycles !== 16'd2) begin n_fail++; $display("FAIL nh_stall_cnt: got %0d expected 2", stall_cycles); end
    endtask

    task automatic test_flush_priority();
        cyc();
        EX_MemRead = 1'b1; EX_rt = 5'd5; ID_instruction = mk_instr(5'd5, 5'd5); branch_taken = 1'b1;
        #1;
        n_checks++;
        if (ctl !== CTL_FLUSH) begin n_fail++; $display("FAIL fp_ctl: got %b expected %b", ctl, CTL_FLUSH); end
        cyc();
        idle();
        #1;
        n_checks++;
        if (ctl !== CTL_RUN) begin n_fail++; $display("FAIL fp_after: got %b expected %b", ctl, CTL_RUN); end
        n_checks++;
        if (stall_cycles !== 16'd2) begin n_fail++; $display("FAIL fp_stall_cnt: got %0d expected 2", stall_cycles); end
    endtask

    task automatic test_mult();
        do_reset();
        cyc();
        mult_start = 1'b1;
        #1;
        n_checks++;
        if (ctl !== CTL_RUN) begin n_fail++; $display("FAIL mult_start_cycle: got %b expected %b", ctl, CTL_RUN); end
        // Hazard inputs and a repeated mult_start during the wait must have no effect.
        for (int k = 0; k < 3; k++) begin
            cyc();
            mult_start = 1'b1; EX_MemRead = 1'b1; EX_rt = 5'd4; ID_instruction = mk_instr(5'd4, 5'd4);
            #1;
            n_checks++;
            if (ctl !== CTL_WAIT) begin n_fail++; $display("FAIL mult_wait_%0d: got %b expected %b", k, ctl, CTL_WAIT); end
        end
        cyc();
        idle();
        #1;
        n_checks++;
        if (ctl !== CTL_RUN) begin n_fail++; $display("FAIL mult_exit: got %b expected %b", ctl, CTL_RUN); end
        n_checks++;
        if (stall_cycles !== 16'd3) begin n_fail++; $display("FAIL mult_stall_cnt: got %0d expected 3", stall_cycles); end
    endtask

    task automatic test_mult_branch();
        do_reset();
        cyc();
        mult_start = 1'b1;
        cyc();
        idle();
        #1;
        n_checks++;
        if (ctl !== CTL_WAIT) begin n_fail++; $display("FAIL mb_wait1: got %b expected %b", ctl, CTL_WAIT); end
        cyc();
        branch_taken = 1'b1;
        #1;
        n_checks++;
        if (ctl !== CTL_WAIT) begin n_fail++; $display("FAIL mb_wait2: got %b expected %b", ctl, CTL_WAIT); end
        cyc();
        branch_taken = 1'b0;
        #1;
        n_checks++;
        if (ctl !== CTL_WAIT) begin n_fail++; $display("FAIL mb_wait3: got %b expected %b", ctl, CTL_WAIT); end
        cyc();
        #1;
        n_checks++;
        if (ctl !== CTL_FLUSH) begin n_fail++; $display("FAIL mb_pending_flush: got %b expected %b", ctl, CTL_FLUSH); end
        cyc();
        #1;
        n_checks++;
        if (ctl !== CTL_RUN) begin n_fail++; $display("FAIL mb_flush_cleared: got %b expected %b", ctl, CTL_RUN); end
    endtask

    task automatic test_start_with_flush();
        do_reset();
        cyc();
        mult_start = 1'b1; branch_taken = 1'b1;
        #1;
        n_checks++;
        if (ctl !== CTL_FLUSH) begin n_fail++; $display("FAIL sf_flush: got %b expected %b", ctl, CTL_FLUSH); end
        for (int k = 0; k < 3; k++) begin
            cyc();
            idle();
            #1;
            n_checks++;
            if (ctl !== CTL_WAIT) begin n_fail++; $display("FAIL sf_wait_%0d: got %b expected %b", k, ctl, CTL_WAIT); end
        end
        cyc();
        #1;
        n_checks++;
        if (ctl !== CTL_RUN) begin n_fail++; $display("FAIL sf_exit_no_flush: got %b expected %b", ctl, CTL_RUN); end
    endtask

    task automatic test_reset_abort();
        do_reset();
        cyc();
        mult_start = 1'b1;
        cyc();
        idle();
        cyc();
        branch_taken = 1'b1; Rst = 1'b1;
        #1;
        n_checks++;
        if (ctl !== CTL_RUN) begin n_fail++; $display("FAIL ra_during_rst: got %b expected %b", ctl, CTL_RUN); end
        n_checks++;
        if (stall_cycles !== 16'd0) begin n_fail++; $display("FAIL ra_rst_cnt: got %0d expected 0", stall_cycles); end
        cyc();
        idle();
        Rst = 1'b0;
        #1;
        n_checks++;
        if (ctl !== CTL_RUN) begin n_fail++; $display("FAIL ra_after_rst: got %b expected %b", ctl, CTL_RUN); end
        cyc();
        #1;
        n_checks++;
        if (ctl !== CTL_RUN) begin n_fail++; $display("FAIL ra_no_late_flush: got %b expected %b", ctl, CTL_RUN); end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 65537; i++) begin
            cyc();
            EX_MemRead = 1'b1; EX_rt = 5'd9; ID_instruction = mk_instr(5'd9, 5'd1);
            if (i == 65534) begin
                #1;
                n_checks++;
                if (stall_cycles !== 16'hFFFE) begin n_fail++; $display("FAIL sat_near: got %h expected fffe", stall_cycles); end
            end
        end
        cyc();
        idle();
        #1;
        n_checks++;
        if (stall_cycles !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %h expected ffff", stall_cycles); end
    endtask

    initial begin
        Rst = 1'b1;
        idle();
        test_reset();
        test_load_use();
        test_no_hazard();
        test_flush_priority();
        test_mult();
        test_mult_branch();
        test_start_with_flush();
        test_reset_abort();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 4, the number of EX cycles a multi-cycle operation occupies (legal range 2..16).
REQ-002 SHALL have port Clk  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port Rst  input  1  reset; one clock, synchronous, active-high.
REQ-004 SHALL have port ID_instruction  input  32  instruction held in the IF/ID register; rs = [25:21], rt = [20:16].
REQ-005 SHALL have port EX_MemRead  input  1  the instruction in EX is a load.
REQ-006 SHALL have port EX_rt  input  5  destination register of the instruction in EX.
REQ-007 SHALL have port branch_taken  input  1  the branch/jump resolved in ID is taken this cycle.
REQ-008 SHALL have port mult_start  input  1  a multi-cycle operation entered EX this cycle.
REQ-009 SHALL have port PC_write  output  1  PC update enable.
REQ-010 SHALL have port IF_ID_stall  output  1  hold the IF/ID register.
REQ-011 SHALL have port IF_ID_flush  output  1  zero the IF/ID register.
REQ-012 SHALL have port ID_EX_bubble  output  1  load a NOP into ID/EX.
REQ-013 SHALL have port ID_EX_stall  output  1  hold ID/EX and EX.
REQ-014 SHALL have port busy  output  1  high while in MULT_WAIT.
REQ-015 SHALL have port stall_cycles  output  16  count of cycles with IF_ID_stall=1, saturating.

Function
REQ-016 SHALL implement FSM states RUN and MULT_WAIT, plus a down-counter cnt and a pending_flush flag.
REQ-017 Load-use hazard SHALL be: state RUN, EX_MemRead=1, EX_rt!=0, and EX_rt equal to rs or rt of ID_instruction.
REQ-018 In RUN with load-use and branch_taken=0, the block SHALL output PC_write=0, IF_ID_stall=1 and ID_EX_bubble=1 combinationally for that cycle only.
REQ-019 In RUN with branch_taken=1 or pending_flush=1, the block SHALL output IF_ID_flush=1, IF_ID_stall=0, PC_write=1 and ID_EX_bubble=0; a flush overrides a load-use hazard.
REQ-020 IF_ID_flush and IF_ID_stall SHALL never both be 1 in the same cycle.
REQ-021 In RUN with no hazard and no flush, outputs SHALL be PC_write=1 with every other control output 0.
REQ-022 In RUN, mult_start=1 SHALL move the FSM to MULT_WAIT at the next edge with cnt=MULT_CYCLES-2; the start cycle itself is not stalled.
REQ-023 mult_start coinciding with a flush SHALL still enter MULT_WAIT.
REQ-024 In MULT_WAIT the block SHALL output PC_write=0, IF_ID_stall=1, ID_EX_stall=1, busy=1, IF_ID_flush=0 and ID_EX_bubble=0.
REQ-025 In MULT_WAIT, cnt SHALL decrement each cycle; at cnt=0 the FSM SHALL return to RUN at the next edge, giving MULT_CYCLES-1 stall cycles in total.
REQ-026 In MULT_WAIT, load-use evaluation SHALL be suppressed and mult_start SHALL be ignored.
REQ-027 branch_taken=1 during MULT_WAIT SHALL set pending_flush, which is applied in the first RUN cycle and then cleared.
REQ-028 stall_cycles SHALL increment by 1 per cycle with IF_ID_stall=1 and hold at 16'hFFFF.

Reset
REQ-029 While Rst=1, the block SHALL force state=RUN, cnt=0, pending_flush=0 and stall_cycles=0.
REQ-030 While Rst=1, outputs SHALL be PC_write=1 with all other outputs 0, regardless of the other inputs.
REQ-031 Rst asserted mid-MULT_WAIT SHALL abort the wait and discard any pending flush.

Structure
REQ-032 A shared pipeline package SHALL hold the FSM state encoding, the instruction field bit positions and the default MULT_CYCLES.
REQ-033 The block SHALL be a single module with no sub-modules; the FSM, counter and hazard compare are local.

Verification
REQ-034 Scenario: EX_MemRead=1, EX_rt=5, ID rs=5 -> exactly one cycle of PC_write=0, IF_ID_stall=1, ID_EX_bubble=1; stall_cycles=1.
REQ-035 Scenario: same hazard with EX_rt=0, or with rs=rt=6 -> no stall.
REQ-036 Scenario: load-use and branch_taken=1 in the same cycle -> IF_ID_flush=1, IF_ID_stall=0, PC_write=1.
REQ-037 Scenario: mult_start=1 with MULT_CYCLES=4 -> busy=1 and IF_ID_stall=1 for exactly 3 cycles, then RUN; stall_cycles=3.
REQ-038 Scenario: branch_taken=1 in the 2nd MULT_WAIT cycle -> IF_ID_flush=1 in the first RUN cycle only.
REQ-039 Scenario: Rst=1 in the 2nd MULT_WAIT cycle -> next cycle busy=0, PC_write=1, no flush.
